fifo_packer: RTL and testbench

Drains 32-bit words from the `fifo` block's read port and packs PACK consecutive words into one wide beat on a valid/ready output. It sits directly downstream of `fifo` and drives that block's `read` input from its `empty` and `output_data` outputs. Partial beats are emitted on a `flush` request, with a per-word keep mask. The accumulator and the output register are separate, so filling continues while a completed beat is stalled.

---
 rtl/fifo_packer.sv | 110 +++++++++++
 tb/tb_fifo_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// Packs PACK consecutive FIFO words into one wide valid/ready beat.
// The accumulator keeps filling while a completed beat waits in the output register.
module fifo_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      fifo_output_data,
  input  logic                       fifo_empty,
  output logic                       fifo_read,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                beat_count
);

  localparam int CW = $clog2(PACK + 1);

  logic [CW-1:0]              acc_cnt_reg;
  logic                       rd_q_reg;
  logic                       flush_pend_reg;
  logic                       out_valid_reg;
  logic [DATA_WIDTH*PACK-1:0] out_data_reg;
  logic [PACK-1:0]            out_keep_reg;
  logic [15:0]                beat_count_reg;

  logic [DATA_WIDTH*PACK-1:0] out_data_next;
  logic [PACK-1:0]            keep_next;
  logic                       out_free;
  logic                       full_beat;
  logic                       part_beat;
  logic                       transfer;
  logic                       flush_idle;

  // Counting the in-flight word keeps a landing from ever overrunning the accumulator.
  assign fifo_read = !fifo_empty && !flush_pend_reg &&
                     ((acc_cnt_reg + {{(CW-1){1'b0}}, rd_q_reg}) < CW'(PACK));

  assign out_free   = !out_valid_reg || out_ready;
  assign full_beat  = (acc_cnt_reg == CW'(PACK));
  assign part_beat  = flush_pend_reg && !rd_q_reg && (acc_cnt_reg != '0);
  assign transfer   = out_free && (full_beat || part_beat);
  assign flush_idle = flush_pend_reg && !rd_q_reg && (acc_cnt_reg == '0);

  for (genvar gi = 0; gi < PACK; gi++) begin : slot
    logic [DATA_WIDTH-1:0] word_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_reg <= '0;
      end else if (rd_q_reg && (acc_cnt_reg == CW'(gi))) begin
        word_reg <= fifo_output_data;
      end
    end

    // Lanes beyond the fill level are zeroed so a partial beat carries no stale data.
    assign keep_next[gi] = (CW'(gi) < acc_cnt_reg);
    assign out_data_next[gi*DATA_WIDTH +: DATA_WIDTH] = keep_next[gi] ? word_reg : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_reg    <= '0;
      rd_q_reg       <= 1'b0;
      flush_pend_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      beat_count_reg <= '0;
    end else begin
      rd_q_reg <= fifo_read;

      if (transfer) begin
        acc_cnt_reg <= '0;
      end else if (rd_q_reg) begin
        acc_cnt_reg <= acc_cnt_reg + 1'b1;
      end

      if (transfer) begin
        out_data_reg  <= out_data_next;
        out_keep_reg  <= keep_next;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      // A flush arriving while one is already pending is absorbed.
      if (flush_pend_reg) begin
        if (transfer || flush_idle) begin
          flush_pend_reg <= 1'b0;
        end
      end else if (flush) begin
        flush_pend_reg <= 1'b1;
      end

      if (out_valid_reg && out_ready) begin
        beat_count_reg <= beat_count_reg + 16'd1;
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_keep   = out_keep_reg;
  assign out_valid  = out_valid_reg;
  assign beat_count = beat_count_reg;

endmodule

// File: tb/tb_fifo_packer.sv
// Self-checking bench for fifo_packer: behavioural source FIFO, beat monitor,
// a table of fill/flush vectors and directed multi-cycle sequences.
module tb_fifo_packer;

  localparam int DW   = 32;
  localparam int PACK = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW-1:0]     fifo_output_data = '0;
  logic              fifo_empty;
  logic              fifo_read;
  logic              flush = 1'b0;
  logic [DW*PACK-1:0] out_data;
  logic [PACK-1:0]   out_keep;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       beat_count;

  fifo_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_output_data (fifo_output_data),
    .fifo_empty       (fifo_empty),
    .fifo_read        (fifo_read),
    .flush            (flush),
    .out_data         (out_data),
    .out_keep         (out_keep),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .beat_count       (beat_count)
  );

  always #5 clk = ~clk;

  // Source FIFO model: read data appears one cycle after an accepted read.
  logic [DW-1:0] fifo_mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      fifo_output_data <= fifo_mem[pop_cnt[7:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Beat monitor: a handshake seen at the falling edge completes at the next rising edge.
  logic [DW*PACK-1:0] beat_data [0:255];
  logic [PACK-1:0]    beat_keep [0:255];
  int beat_n = 0;
  int viol   = 0;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beat_data[beat_n[7:0]] = out_data;
      beat_keep[beat_n[7:0]] = out_keep;
      beat_n = beat_n + 1;
    end
    if (fifo_read && fifo_empty) viol = viol + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[push_cnt[7:0]] = w;
    push_cnt = push_cnt + 1;
  endtask

  task automatic wait_beats(input int base, input int n, input int budget);
    int waited;
    waited = 0;
    while ((beat_n - base) < n && waited < budget) begin
      cyc();
      waited++;
    end
    check("beats_arrived", beat_n - base, n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc();
  endtask

  typedef struct {
    int           n;
    logic [127:0] words;
    bit           do_flush;
    int           exp_beats;
    logic [127:0] exp_data;
    logic [3:0]   exp_keep;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [127:0] exp;
    int base;
    int lat;

    vecs[0] = '{3, 128'h00000000_00000004_00000002_00000000, 1'b1, 1,
                128'h00000000_00000004_00000002_00000000, 4'b0111};
    vecs[1] = '{0, 128'h0, 1'b1, 0, 128'h0, 4'b0000};
    vecs[2] = '{1, 128'h00000000_00000000_00000000_DEADBEEF, 1'b1, 1,
                128'h00000000_00000000_00000000_DEADBEEF, 4'b0001};
    vecs[3] = '{2, 128'h00000000_00000000_00000022_00000011, 1'b1, 1,
                128'h00000000_00000000_00000022_00000011, 4'b0011};
    vecs[4] = '{4, 128'h000000A4_000000A3_000000A2_000000A1, 1'b0, 1,
                128'h000000A4_000000A3_000000A2_000000A1, 4'b1111};
    vecs[5] = '{4, 128'h000000B4_000000B3_000000B2_000000B1, 1'b1, 1,
                128'h000000B4_000000B3_000000B2_000000B1, 4'b1111};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_fifo_read", fifo_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_beat_count", beat_count, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Full beats, consumer always ready
    base = beat_n;
    for (int i = 0; i < 32; i++) push(DW'(2 * i));
    wait_beats(base, 8, 300);
    check("first_beat_data", beat_data[base[7:0]], 128'h00000006_00000004_00000002_00000000);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) exp[k*32 +: 32] = 32'(2 * (4 * i + k));
      check($sformatf("full_beat%0d_data", i), beat_data[(base + i) % 256], exp);
      check($sformatf("full_beat%0d_keep", i), beat_keep[(base + i) % 256], 4'hF);
    end
    repeat (5) cyc();
    check("full_beat_count", beat_count, 8);
    check("full_idle_valid", out_valid, 0);

    // Back-pressure: first beat held while the accumulator fills behind it
    do_reset();
    out_ready = 1'b0;
    base = beat_n;
    for (int i = 0; i < 32; i++) push(DW'(2 * i));
    repeat (25) cyc();
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 128'h00000006_00000004_00000002_00000000);
    check("bp_fifo_read", fifo_read, 0);
    check("bp_acc_words", {dut.slot[3].word_reg, dut.slot[2].word_reg,
                           dut.slot[1].word_reg, dut.slot[0].word_reg},
          128'h0000000E_0000000C_0000000A_00000008);
    check("bp_acc_cnt", dut.acc_cnt_reg, 4);
    out_ready = 1'b1;
    wait_beats(base, 8, 300);
    repeat (5) cyc();
    check("bp_no_dup", beat_n - base, 8);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) exp[k*32 +: 32] = 32'(2 * (4 * i + k));
      check($sformatf("bp_beat%0d_data", i), beat_data[(base + i) % 256], exp);
    end
    check("bp_beat_count", beat_count, 8);

    // Table of fill levels with and without flush
    for (int e = 0; e < 6; e++) begin
      base = beat_n;
      for (int k = 0; k < vecs[e].n; k++) push(vecs[e].words[k*32 +: 32]);
      repeat (8) cyc();
      if (vecs[e].do_flush) begin
        flush = 1'b1;
        cyc();
        flush = 1'b0;
      end
      repeat (6) cyc();
      check($sformatf("vec%0d_beats", e), beat_n - base, vecs[e].exp_beats);
      if (vecs[e].exp_beats == 1 && beat_n > base) begin
        check($sformatf("vec%0d_data", e), beat_data[base[7:0]], vecs[e].exp_data);
        check($sformatf("vec%0d_keep", e), beat_keep[base[7:0]], vecs[e].exp_keep);
      end
    end

    // Flush while a word is in flight
    base = beat_n;
    push(32'h51);
    repeat (4) cyc();
    push(32'h52);
    @(negedge clk);
    check("inflight_read", fifo_read, 1);
    @(posedge clk);
    #1 flush = 1'b1;
    check("inflight_rd_q", dut.rd_q_reg, 1);
    cyc();
    flush = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4) begin
      cyc();
      lat++;
    end
    check("inflight_latency_ok", (lat <= 2), 1);
    repeat (2) cyc();
    check("inflight_beats", beat_n - base, 1);
    check("inflight_data", beat_data[base[7:0]], 128'h00000000_00000000_00000052_00000051);
    check("inflight_keep", beat_keep[base[7:0]], 4'b0011);

    // Asynchronous reset in the middle of a fill
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h100 + i));
    repeat (10) cyc();
    push(32'h104);
    push(32'h105);
    repeat (6) cyc();
    check("mid_acc_cnt", dut.acc_cnt_reg, 2);
    check("mid_valid_before", out_valid, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_keep", out_keep, 0);
    check("arst_beat_count", beat_count, 0);
    check("arst_fifo_read", fifo_read, 0);
    check("arst_acc_cnt", dut.acc_cnt_reg, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    out_ready = 1'b1;
    base = beat_n;
    for (int i = 0; i < 4; i++) push(DW'(32'h110 + i));
    wait_beats(base, 1, 50);
    check("post_rst_data", beat_data[base[7:0]], 128'h00000113_00000112_00000111_00000110);
    check("post_rst_keep", beat_keep[base[7:0]], 4'hF);

    // beat_count wrap
    repeat (4) cyc();
    force dut.beat_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.beat_count_reg;
    cyc();
    base = beat_n;
    for (int i = 0; i < 4; i++) push(DW'(32'h200 + i));
    wait_beats(base, 1, 50);
    repeat (3) cyc();
    check("wrap_beat_count", beat_count, 16'h0000);

    check("no_read_when_empty", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
